// File: rtl/port_b_pair_capture.sv
// port_b_pair_capture
// Assembles two-word records fetched over BRAM port B, routes the first boot
// record to the global parameter registers and queues every later record in a
// small first-word-fall-through FIFO. Sequence violations and dropped records
// are latched in sticky flags; nothing here ever back-pressures the fetcher.
module port_b_pair_capture #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     boot_mode,
    input  logic                     port_b_start_out,
    input  logic                     port_b_done,
    input  logic [DATA_W-1:0]        dout_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_w0,
    output logic [DATA_W-1:0]        out_w1,
    output logic [DATA_W-1:0]        param_a,
    output logic [DATA_W-1:0]        param_b,
    output logic                     params_loaded,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_W0 = 2'd1,
        HAVE_W1 = 2'd2
    } state_t;

    state_t state_q, state_d;

    // decoded FSM actions
    logic lat_w0, lat_w1, commit, perr;

    logic [DATA_W-1:0] w0_q, w1_q;
    logic [DATA_W-1:0] param_a_q, param_b_q;
    logic              params_loaded_q, overflow_q, proto_err_q;

    logic [2*DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;

    logic to_params, push_req, push_ok, pop, full, empty;

    // capture FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // capture FSM next-state: a start always restarts capture, even mid-record
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (port_b_start_out) state_d = HAVE_W0;
            HAVE_W0: if (!port_b_start_out) state_d = HAVE_W1;
            HAVE_W1: state_d = port_b_start_out ? HAVE_W0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // capture FSM actions: which word to latch, commit, and violation strobes
    always_comb begin
        lat_w0 = 1'b0;
        lat_w1 = 1'b0;
        commit = 1'b0;
        perr   = 1'b0;
        case (state_q)
            IDLE: begin
                lat_w0 = port_b_start_out;
                perr   = port_b_done;
            end
            HAVE_W0: begin
                if (port_b_start_out) begin
                    lat_w0 = 1'b1;
                    perr   = 1'b1;
                end else begin
                    lat_w1 = 1'b1;
                end
            end
            HAVE_W1: begin
                if (port_b_start_out) begin
                    // done alongside a new start still loses the old record
                    lat_w0 = 1'b1;
                    perr   = 1'b1;
                end else if (port_b_done) begin
                    commit = 1'b1;
                end else begin
                    perr   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // commit routing and FIFO handshake decode
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        to_params = commit && boot_mode && !params_loaded_q;
        push_req  = commit && !to_params;
        pop       = !empty && out_ready;
        // a pop in the same cycle frees the slot a full FIFO needs
        push_ok   = push_req && (!full || pop);
    end

    // record assembly registers
    always_ff @(posedge clk) begin
        if (rst) begin
            w0_q <= '0;
            w1_q <= '0;
        end else begin
            if (lat_w0) w0_q <= dout_b;
            if (lat_w1) w1_q <= dout_b;
        end
    end

    // boot parameters and sticky status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            param_a_q       <= '0;
            param_b_q       <= '0;
            params_loaded_q <= 1'b0;
            overflow_q      <= 1'b0;
            proto_err_q     <= 1'b0;
        end else begin
            if (to_params) begin
                param_a_q       <= w0_q;
                param_b_q       <= w1_q;
                params_loaded_q <= 1'b1;
            end
            if (push_req && !push_ok) overflow_q  <= 1'b1;
            if (perr)                 proto_err_q <= 1'b1;
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {w0_q, w1_q};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_valid     = !empty;
    assign out_w0        = mem_q[rd_ptr_q][2*DATA_W-1:DATA_W];
    assign out_w1        = mem_q[rd_ptr_q][DATA_W-1:0];
    assign param_a       = param_a_q;
    assign param_b       = param_b_q;
    assign params_loaded = params_loaded_q;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_port_b_pair_capture.sv
// Self-checking bench for port_b_pair_capture: expected FIFO records are queued
// as fetches are driven and compared whenever the DUT pops a record.
module tb_port_b_pair_capture;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              boot_mode = 1'b0;
    logic              port_b_start_out = 1'b0;
    logic              port_b_done = 1'b0;
    logic [DATA_W-1:0] dout_b = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_w0, out_w1, param_a, param_b;
    logic              params_loaded;
    logic [CW-1:0]     fifo_count;
    logic              overflow, proto_err;

    int checks   = 0;
    int failures = 0;
    logic [2*DATA_W-1:0] exp_q [$];

    port_b_pair_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .boot_mode(boot_mode),
        .port_b_start_out(port_b_start_out), .port_b_done(port_b_done),
        .dout_b(dout_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_w0(out_w0), .out_w1(out_w1), .param_a(param_a), .param_b(param_b),
        .params_loaded(params_loaded), .fifo_count(fifo_count),
        .overflow(overflow), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // advance one cycle; inputs change and outputs are read 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: a pop happens at the next edge whenever valid&ready are high now
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'(out_valid), 32'd0);
            end else begin
                logic [2*DATA_W-1:0] e;
                e = exp_q.pop_front();
                chk("pop_w0", 32'(out_w0), 32'(e[2*DATA_W-1:DATA_W]));
                chk("pop_w1", 32'(out_w1), 32'(e[DATA_W-1:0]));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        port_b_start_out = 1'b0;
        port_b_done = 1'b0;
        out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // nominal fetch; returns 1ns after the commit edge (S+3)
    task automatic fetch(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input bit expect_fifo, input bit rdy_on_done);
        port_b_start_out = 1'b1;
        dout_b = a;
        cyc();
        port_b_start_out = 1'b0;
        dout_b = b;
        cyc();
        port_b_done = 1'b1;
        dout_b = '0;
        if (rdy_on_done) out_ready = 1'b1;
        if (expect_fifo) exp_q.push_back({a, b});
        cyc();
        port_b_done = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 4 * DEPTH) begin
            cyc();
            n++;
        end
        out_ready = 1'b0;
        chk("drain_timeout", 32'(out_valid), 32'd0);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_count", 32'(fifo_count), 32'd0);
    endtask

    initial begin
        do_reset();
        // reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ploaded", 32'(params_loaded), 32'd0);
        chk("rst_flags", {30'd0, overflow, proto_err}, 32'd0);
        chk("rst_w0", 32'(out_w0), 32'd0);

        // boot load
        boot_mode = 1'b1;
        fetch(16'h1234, 16'h5678, 1'b0, 1'b0);
        chk("boot_ploaded", 32'(params_loaded), 32'd1);
        chk("boot_pa", 32'(param_a), 32'h1234);
        chk("boot_pb", 32'(param_b), 32'h5678);
        chk("boot_valid", 32'(out_valid), 32'd0);

        // normal record
        boot_mode = 1'b0;
        fetch(16'h00AA, 16'h00BB, 1'b1, 1'b0);
        chk("norm_valid", 32'(out_valid), 32'd1);
        chk("norm_w0", 32'(out_w0), 32'h00AA);
        chk("norm_w1", 32'(out_w1), 32'h00BB);
        chk("norm_count", 32'(fifo_count), 32'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("norm_popped", 32'(fifo_count), 32'd0);
        chk("norm_pa_kept", 32'(param_a), 32'h1234);

        // fill and overflow
        do_reset();
        for (int i = 1; i <= 5; i++)
            fetch(16'(16'h0100 + i), 16'(16'h0200 + i), i <= DEPTH, 1'b0);
        chk("fill_count", 32'(fifo_count), 32'd4);
        chk("fill_ovf", 32'(overflow), 32'd1);
        chk("fill_head_w0", 32'(out_w0), 32'h0101);
        chk("fill_head_w1", 32'(out_w1), 32'h0201);
        drain();

        // full with simultaneous pop
        do_reset();
        for (int i = 1; i <= 4; i++)
            fetch(16'(16'h0300 + i), 16'(16'h0400 + i), 1'b1, 1'b0);
        chk("fp_full", 32'(fifo_count), 32'd4);
        fetch(16'h0305, 16'h0405, 1'b1, 1'b1);
        chk("fp_ovf", 32'(overflow), 32'd0);
        chk("fp_count", 32'(fifo_count), 32'd4);
        chk("fp_head", 32'(out_w0), 32'h0302);
        drain();

        // protocol: done with no start
        do_reset();
        fetch(16'h0A0A, 16'h0B0B, 1'b1, 1'b0);
        port_b_done = 1'b1;
        cyc();
        port_b_done = 1'b0;
        chk("perr_done", 32'(proto_err), 32'd1);
        chk("perr_count", 32'(fifo_count), 32'd1);
        drain();

        // protocol: restart at S+1
        do_reset();
        port_b_start_out = 1'b1; dout_b = 16'h1111; cyc();
        port_b_start_out = 1'b1; dout_b = 16'h2222; cyc();
        port_b_start_out = 1'b0; dout_b = 16'h3333; cyc();
        port_b_done = 1'b1; dout_b = 16'h4444;
        exp_q.push_back({16'h2222, 16'h3333});
        cyc();
        port_b_done = 1'b0;
        chk("restart_perr", 32'(proto_err), 32'd1);
        chk("restart_count", 32'(fifo_count), 32'd1);
        chk("restart_w0", 32'(out_w0), 32'h2222);
        chk("restart_w1", 32'(out_w1), 32'h3333);
        drain();

        // reset mid-capture
        do_reset();
        boot_mode = 1'b1;
        fetch(16'hBEEF, 16'hCAFE, 1'b0, 1'b0);
        fetch(16'h5555, 16'h6666, 1'b1, 1'b0);
        port_b_start_out = 1'b1; dout_b = 16'h7777; cyc();
        port_b_start_out = 1'b0; dout_b = 16'h8888; rst = 1'b1; cyc();
        rst = 1'b0;
        exp_q.delete();
        chk("mid_outs", {26'd0, out_valid, params_loaded, overflow, proto_err, 2'b00}, 32'd0);
        chk("mid_pa", 32'(param_a), 32'd0);
        chk("mid_w0", 32'(out_w0), 32'd0);
        chk("mid_count", 32'(fifo_count), 32'd0);
        port_b_done = 1'b1; cyc();
        port_b_done = 1'b0;
        chk("mid_nocommit", 32'(fifo_count), 32'd0);
        chk("mid_noparams", 32'(params_loaded), 32'd0);
        chk("mid_perr", 32'(proto_err), 32'd1);
        boot_mode = 1'b0;

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/port_b_pair_capture.md
# port_b_pair_capture

Captures the two-word records read from BRAM port B for each fetch sequenced by the port B address generator, and commits each record as a unit. Sits directly downstream of the port B address generator and the BRAM read port. During boot the first record goes to global parameter registers; after that, records are buffered in a small FWFT FIFO for the synaptic accumulator, with a valid/ready handshake. Protocol violations and overflows are recorded in sticky flags; the block never stalls the address generator.

## Interface
- DATA_W, 16, width of one BRAM word
- DEPTH, 4, FIFO depth in records; power of 2, at least 2
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- boot_mode  in  1  high while biases/global parameters are being fetched
- port_b_start_out  in  1  one-cycle pulse; word 0 of the record is valid on dout_b this cycle
- port_b_done  in  1  one-cycle pulse; the fetch is complete (nominally 2 cycles after start_out)
- dout_b  in  DATA_W  BRAM port B read data
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts the head record when out_valid is high
- out_w0  out  DATA_W  head record, word 0
- out_w1  out  DATA_W  head record, word 1
- param_a  out  DATA_W  boot record, word 0
- param_b  out  DATA_W  boot record, word 1
- params_loaded  out  1  boot record captured
- fifo_count  out  $clog2(DEPTH)+1  records held
- overflow  out  1  sticky: a record was dropped because the FIFO was full
- proto_err  out  1  sticky: port_b_start_out/port_b_done sequence violated

## Operation
- Capture FSM states: IDLE, HAVE_W0, HAVE_W1.
- IDLE: on port_b_start_out, latch dout_b into w0_r and go to HAVE_W0. A port_b_done seen in IDLE sets proto_err and is otherwise ignored.
- HAVE_W0: unconditionally latch dout_b into w1_r and go to HAVE_W1.
  - If port_b_start_out is high in this cycle: set proto_err, latch dout_b into w0_r instead, and stay in HAVE_W0.
- HAVE_W1:
  - port_b_done high: commit {w0_r, w1_r} and go to IDLE.
  - port_b_start_out high (with or without done): set proto_err, discard the partial record, latch a new w0, go to HAVE_W0. If done is also high, the old record is discarded, not committed.
  - Neither high: set proto_err, discard the record, go to IDLE.
- Commit routing:
  - boot_mode=1 and params_loaded=0: write param_a/param_b and set params_loaded. The FIFO is untouched.
  - Otherwise: push to the FIFO. Records committed during boot_mode after params_loaded=1 also go to the FIFO.
- FIFO: circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap naturally. out_w0/out_w1 always show the entry at the read pointer (FWFT).
- Pop occurs when out_valid && out_ready.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted and fifo_count stays at DEPTH.
  - Otherwise the record is dropped and overflow is set.
- Push and pop in the same cycle when not empty: count unchanged.
- Push when empty: out_valid rises the next cycle. There is no combinational bypass.
- params_loaded, overflow and proto_err clear only on rst.

## Timing
- Reset values: all outputs 0, FSM in IDLE, pointers 0, w0_r/w1_r 0.
- rst mid-capture discards the partial record; the FIFO is emptied. rst has priority over all other inputs.
- Nominal sequence, with start_out at cycle S:
  - S: w0 latched
  - S+1: w1 latched
  - S+2: port_b_done, record committed at the end of S+2
  - S+3: out_valid=1 (or params_loaded=1); fifo_count updates at the same edge
- Back-to-back fetches with start_out at S+3 are supported with no lost cycle.
- The next start_out may also arrive at S+2 together with done. That is a protocol violation: the old record is dropped and capture restarts (see Operation).
- out_ready is sampled only when out_valid=1. out_w0/out_w1 are stable while out_valid=1 and there is no pop.
- Maximum throughput: one record per 3 cycles in, one record per cycle out.

## Test plan
- Boot load: rst, boot_mode=1, start_out with dout_b=0x1234, then 0x5678, then done -> params_loaded=1, param_a=0x1234, param_b=0x5678 at S+3; out_valid stays 0.
- Normal record: params_loaded=1, boot_mode=0, words 0x00AA and 0x00BB with done -> out_valid=1 at S+3, out_w0=0x00AA, out_w1=0x00BB; out_ready=1 -> fifo_count=0 the next cycle.
- Fill and overflow (DEPTH=4, out_ready=0): 5 records -> fifo_count=4, overflow=1 after the 5th, head still holds record 1. Then drain -> records 1-4 in order and out_valid=0 after the 4th pop.
- Full with simultaneous pop: FIFO full, out_ready=1 in the commit cycle of a 5th record -> overflow stays 0, fifo_count=4, and record 5 appears after records 2-4.
- Protocol errors: done with no start -> proto_err=1, fifo_count unchanged. Start at S then start again at S+1 -> the committed record is {word at S+1, word at S+2}.
- Reset mid-capture: rst at S+1 -> after release all outputs 0, and no record is committed by a done at S+2.
